// File: rtl/setn_release_sequencer_if.sv
// Handshake and SETN bundle between the set sequencer and its requester / flop banks.
interface setn_release_sequencer_if #(parameter int NBANK = 4);
  logic             req;
  logic             ack;
  logic             busy;
  logic             done;
  logic [NBANK-1:0] setn;

  modport master (output req, input ack, busy, done, setn);
  modport slave  (input req, output ack, busy, done, setn);
endinterface

// File: rtl/setn_release_sequencer.sv
// Active-low SETN generator: asynchronous set, synchronous bank-ordered release,
// re-runnable through a four-phase REQ/ACK handshake.
module setn_release_sequencer #(
  parameter int NBANK       = 4,
  parameter int HOLD_CYC    = 8,
  parameter int GAP_CYC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                     clk,
  input logic                     rst,
  setn_release_sequencer_if.slave bus
);
  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] LAST    = IW'(NBANK - 1);

  typedef enum logic [1:0] {SYNC, HOLD, REL, IDLE} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [CW-1:0]          cnt, cnt_d;
  logic [IW-1:0]          idx, idx_d;
  logic [NBANK-1:0]       setn, setn_d;
  logic                   busy, busy_d, done, done_d, ack, ack_d, by_req, by_req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '1;
      state     <= SYNC;
      cnt       <= '0;
      idx       <= '0;
      setn      <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      ack       <= 1'b0;
      by_req    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b0};
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      setn      <= setn_d;
      busy      <= busy_d;
      done      <= done_d;
      ack       <= ack_d;
      by_req    <= by_req_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    setn_d   = setn;
    busy_d   = busy;
    done_d   = done;
    ack_d    = ack;
    by_req_d = by_req;
    case (state)
      // Leave on the edge where the last sync flop clears, so HOLD starts with the internal release.
      SYNC: if (sync_pipe[SYNC_STAGES-1 -: 2] == 2'b10) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end
      HOLD: begin
        if (cnt != '0) cnt_d = cnt - 1'b1;
        else begin
          setn_d[0] = 1'b1;
          if (NBANK == 1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ack_d   = by_req;
          end else begin
            state_d = REL;
            cnt_d   = GAP_LD;
            idx_d   = IW'(1);
          end
        end
      end
      REL: begin
        if (cnt != '0) cnt_d = cnt - 1'b1;
        else begin
          setn_d[idx] = 1'b1;
          cnt_d       = GAP_LD;
          if (idx == LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ack_d   = by_req;
          end else idx_d = idx + 1'b1;
        end
      end
      IDLE: begin
        if (ack && !bus.req) ack_d = 1'b0;
        else if (bus.req && !ack) begin
          state_d  = HOLD;
          cnt_d    = HOLD_LD;
          setn_d   = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          by_req_d = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign bus.setn = setn;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.ack  = ack;
endmodule

// File: tb/tb_setn_release_sequencer.sv
// Scoreboard bench: expected output events are queued by stimulus, monitors pop on every output change.
module tb_setn_release_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0, rst1 = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  setn_release_sequencer_if #(.NBANK(4)) bus0();
  setn_release_sequencer_if #(.NBANK(1)) bus1();

  setn_release_sequencer #(.NBANK(4), .HOLD_CYC(8), .GAP_CYC(4), .SYNC_STAGES(2))
    dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  setn_release_sequencer #(.NBANK(1), .HOLD_CYC(1), .GAP_CYC(4), .SYNC_STAGES(2))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  typedef struct packed {
    int         cyc;
    logic [3:0] setn;
    logic       busy;
    logic       done;
    logic       ack;
  } ev_t;

  ev_t q0[$], q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp0(input int c, input logic [3:0] s, input logic b, input logic d, input logic k);
    q0.push_back('{cyc: c, setn: s, busy: b, done: d, ack: k});
  endtask

  task automatic exp1(input int c, input logic s, input logic b, input logic d, input logic k);
    q1.push_back('{cyc: c, setn: {3'b000, s}, busy: b, done: d, ack: k});
  endtask

  task automatic check(input string nm, input ev_t e, input ev_t a);
    n_chk++;
    if (e !== a) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d setn=%b busy=%b done=%b ack=%b, want cyc=%0d setn=%b busy=%b done=%b ack=%b",
               nm, a.cyc, a.setn, a.busy, a.done, a.ack, e.cyc, e.setn, e.busy, e.done, e.ack);
    end
  endtask

  task automatic unexpected(input string nm, input ev_t a);
    n_chk++;
    n_fail++;
    $display("FAIL %s unexpected event: cyc=%0d setn=%b busy=%b done=%b ack=%b",
             nm, a.cyc, a.setn, a.busy, a.done, a.ack);
  endtask

  // Monitors: sample 1ns after each clock edge or reset assertion, report changes only
  logic [6:0] last0, last1;
  bit         have0 = 0, have1 = 0;

  always @(posedge clk or posedge rst0) begin
    ev_t a;
    #1;
    a = '{cyc: cyc, setn: bus0.setn, busy: bus0.busy, done: bus0.done, ack: bus0.ack};
    if (!have0 || {a.setn, a.busy, a.done, a.ack} !== last0) begin
      have0 = 1;
      last0 = {a.setn, a.busy, a.done, a.ack};
      if (q0.size() == 0) unexpected("dut0", a);
      else check("dut0_event", q0.pop_front(), a);
    end
  end

  always @(posedge clk or posedge rst1) begin
    ev_t a;
    #1;
    a = '{cyc: cyc, setn: {3'b000, bus1.setn}, busy: bus1.busy, done: bus1.done, ack: bus1.ack};
    if (!have1 || {a.setn, a.busy, a.done, a.ack} !== last1) begin
      have1 = 1;
      last1 = {a.setn, a.busy, a.done, a.ack};
      if (q1.size() == 0) unexpected("dut1", a);
      else check("dut1_event", q1.pop_front(), a);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Four bank releases starting at t0, GAP=4 apart; last one completes the sequence.
  task automatic rel0(input int t0, input logic k);
    for (int b = 0; b < 4; b++) begin
      logic [3:0] m;
      m = 4'((1 << (b + 1)) - 1);
      exp0(t0 + 4 * b, m, b != 3, b == 3, (b == 3) ? k : 1'b0);
    end
  endtask

  task automatic pulse0();
    #1 rst0 = 1'b1;
    #3 rst0 = 1'b0;
  endtask

  task automatic stim0();
    int c0, r, c1, c2, r2, c3;
    bus0.req = 1'b0;
    exp0(0, 4'b0000, 1, 0, 0);
    #1 rst0 = 1'b1;
    wait_cyc(2);
    c0 = cyc;
    rst0 = 1'b0;
    rel0(c0 + 10, 1'b0);
    // Request handshake, REQ held 20 cycles past ACK
    r = c0 + 50;
    wait_cyc(r - 1);
    exp0(r, 4'b0000, 1, 0, 0);
    bus0.req = 1'b1;
    rel0(r + 8, 1'b1);
    wait_cyc(r + 39);
    exp0(r + 40, 4'b1111, 0, 1, 0);
    bus0.req = 1'b0;
    // Narrow reset, then another narrow reset between edges 15 and 16
    wait_cyc(r + 50);
    c1 = cyc;
    exp0(c1, 4'b0000, 1, 0, 0);
    pulse0();
    exp0(c1 + 10, 4'b0001, 1, 0, 0);
    exp0(c1 + 14, 4'b0011, 1, 0, 0);
    wait_cyc(c1 + 15);
    c2 = cyc;
    exp0(c2, 4'b0000, 1, 0, 0);
    pulse0();
    rel0(c2 + 10, 1'b0);
    // Reset while ACK is high with REQ still asserted
    r2 = c2 + 40;
    wait_cyc(r2 - 1);
    exp0(r2, 4'b0000, 1, 0, 0);
    bus0.req = 1'b1;
    rel0(r2 + 8, 1'b1);
    wait_cyc(r2 + 24);
    c3 = cyc;
    exp0(c3, 4'b0000, 1, 0, 0);
    pulse0();
    wait_cyc(c3 + 3);
    bus0.req = 1'b0;
    rel0(c3 + 10, 1'b0);
    wait_cyc(c3 + 30);
  endtask

  task automatic stim1();
    int c0;
    bus1.req = 1'b0;
    exp1(0, 1'b0, 1, 0, 0);
    #1 rst1 = 1'b1;
    wait_cyc(2);
    c0 = cyc;
    rst1 = 1'b0;
    exp1(c0 + 3, 1'b1, 0, 1, 0);
    // REQ pulse sampled only in HOLD must be dropped
    wait_cyc(c0 + 2);
    bus1.req = 1'b1;
    wait_cyc(c0 + 3);
    bus1.req = 1'b0;
    wait_cyc(c0 + 9);
    exp1(c0 + 10, 1'b0, 1, 0, 0);
    exp1(c0 + 11, 1'b1, 0, 1, 1);
    bus1.req = 1'b1;
    wait_cyc(c0 + 14);
    exp1(c0 + 15, 1'b1, 0, 1, 0);
    bus1.req = 1'b0;
    wait_cyc(c0 + 30);
  endtask

  initial begin
    fork
      stim0();
      stim1();
    join
    repeat (5) @(negedge clk);
    n_chk++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL dut0_missing: got %0d events outstanding, want 0 (next cyc=%0d)", q0.size(), q0[0].cyc);
    end
    n_chk++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL dut1_missing: got %0d events outstanding, want 0 (next cyc=%0d)", q1.size(), q1[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/setn_release_sequencer.md
# setn_release_sequencer

Generates the active-low asynchronous set nets (SETN) for banks of set-type flip-flops in the gf180mcu mcu9t5v0 library. The set is asserted asynchronously, and released synchronously and in a fixed bank order with programmable spacing. A four-phase REQ/ACK handshake lets logic re-run the set sequence without a chip reset. The block sits between the global reset source and the SETN pins of the downstream flop banks.

## Interface
- NBANK, 4: number of SETN banks; ≥1.
- HOLD_CYC, 8: CLK cycles all banks stay set after the sequence starts; ≥1.
- GAP_CYC, 4: CLK cycles between successive bank releases; ≥1, unused when NBANK=1.
- SYNC_STAGES, 2: reset-release synchronizer depth; ≥2.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  1  re-set request, four-phase, synchronous to CLK.
- ACK  out  1  re-set complete, four-phase acknowledge.
- SETN  out  NBANK  per-bank active-low set; bit k released k-th.
- BUSY  out  1  sequence in progress.
- DONE  out  1  all banks released.

## Operation
- While RST=1, outputs are forced asynchronously: SETN=all 0, BUSY=1, DONE=0, ACK=0. The synchronizer chain is held all-1 and the FSM is in SYNC.
- States are SYNC, HOLD, REL, IDLE.
  - SYNC: wait until the synchronizer chain has shifted 0 through all SYNC_STAGES flops, then go to HOLD.
  - HOLD: count HOLD_CYC cycles with SETN all 0. Then release SETN[0] and go to REL with bank index 1.
  - REL: count GAP_CYC cycles, then release SETN[index] and increment the index. After SETN[NBANK-1] is released, set DONE=1 and BUSY=0 and go to IDLE.
  - IDLE: SETN is all 1. If REQ=1 and ACK=0, set SETN=all 0 synchronously, BUSY=1, DONE=0, and go to HOLD.
- Handshake:
  - ACK rises at the edge where DONE rises, but only for a REQ-initiated sequence; a reset-initiated sequence never raises ACK.
  - ACK stays high while REQ=1. ACK falls at the first edge where REQ=0.
  - REQ=1 while ACK=1 does not retrigger the sequence.
  - REQ changes during HOLD or REL are ignored.
  - The requester must hold REQ high until ACK=1.
- SETN bits are individual flops: asynchronously cleared by RST, and only ever driven by a clean registered edge.
- A released bank stays released until the next RST or accepted REQ.
- Counter width is clog2(max(HOLD_CYC,GAP_CYC)+1). The counter reloads on every state entry; there is no wrap beyond terminal count.
- NBANK=1: HOLD goes directly to IDLE on release of SETN[0]; REL is never entered.

## Timing
- Edge numbering, reset path: edge 1 is the first rising CLK edge with RST=0.
  - Internal reset releases at edge SYNC_STAGES.
  - SETN[k] rises at edge SYNC_STAGES+HOLD_CYC+k·GAP_CYC.
  - DONE rises and BUSY falls at the edge where SETN[NBANK-1] rises.
- Request path: REQ is first sampled 1 in IDLE at edge r.
  - At edge r: SETN=0, BUSY=1, DONE=0.
  - SETN[k] rises at edge r+HOLD_CYC+k·GAP_CYC.
  - ACK rises with DONE.
- Reset mid-operation: the RST rising edge forces all reset values immediately, with no clock needed, and the full sequence restarts from SYNC.
  - This includes RST pulses narrower than a CLK period.
  - Any pending handshake is dropped: ACK=0.
- RST and REQ together: RST wins, and REQ is ignored until IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs, except the asynchronous RST clear.

## Test plan
- Reset release (defaults): deassert RST → SETN[0..3] rise at edges 10/14/18/22, DONE=1 and BUSY=0 at edge 22, ACK stays 0.
- Re-set handshake: in IDLE, REQ=1 sampled at edge r=50 → SETN=0000 at 50, bits rise at 58/62/66/70, ACK=1 at 70. Drop REQ at 75 → ACK=0 at the edge of 75.
- Held REQ: keep REQ=1 after ACK=1 for 20 cycles → no retrigger; SETN stays 1111.
- Mid-sequence reset: pulse RST for 0.3 CLK period between edges 15 and 16 of the reset-release sequence → SETN=0000 immediately, ACK=0, sequence restarts from edge 1.
- Boundary parameters: NBANK=1, HOLD_CYC=1, SYNC_STAGES=2 → SETN[0] and DONE rise at edge 3. Also REQ asserted during HOLD is ignored and no extra sequence follows.
